jpeg_bitstream_packer: RTL
==========================

# jpeg_bitstream_packer

Packs the variable-length Huffman codes produced by the entropy-encoder controller into a byte-aligned JPEG entropy-coded stream. Codes are appended MSB-first to a 32-bit accumulator, and whole bytes leave through a valid/ready byte port. With stuffing compiled in, a 0x00 is inserted after every emitted 0xFF. On a flush request the block pads the final partial byte with 1s, optionally appends the EOI marker (0xFF 0xD9), and signals completion. It sits directly downstream of the Huffman encoder controller and feeds the output byte FIFO / host interface.

## Interface
Parameters:
- EMIT_EOI, 1, 1: append 0xFF 0xD9 after flush padding; 0: no marker.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- jpeg_out_enable  in  1  code valid strobe, one cycle per code.
- jpeg_out  in  16  code, right-aligned; only the low jpeg_code_len bits are used.
- jpeg_code_len  in  5  code length 0..16; 0 = no-op; values 17..31 are treated as overflow.
- flush  in  1  end-of-scan request, one-cycle pulse.
- in_ready  out  1  a code of any length is accepted this cycle.
- byte_out  out  8  stream byte.
- byte_valid  out  1  byte_out holds a byte.
- byte_ready  in  1  consumer accepts byte_out.
- flush_done  out  1  one-cycle pulse: the last flushed byte has been handshaken.
- overflow  out  1  sticky; a code was dropped.
- byte_count  out  16  bytes handshaken (including stuffing and EOI); wraps at 0xFFFF.

## Operation
- State: acc[31:0] is left-aligned, with valid bits at the top. cnt[5:0] ranges 0..32. The output register (byte_out/byte_valid) holds one byte. stuff_pend is 1 bit.
- in_ready = (state==RUN) && (cnt<=16).
- Accept: jpeg_out_enable && in_ready && len in 1..16. The code's low len bits are placed immediately below the current valid bits, and cnt += len.
- Drop: jpeg_out_enable && (!in_ready || len>16). overflow is set and acc is unchanged. A len of 0 is ignored and does not set overflow.
- Output slot is free when !byte_valid || byte_ready.
- Slot free, priority order:
  - stuff_pend: load 0x00 and clear stuff_pend.
  - cnt>=8: load acc[31:24], shift acc left 8, and cnt -= 8.
  - In EOI states: load the marker byte.
  - Otherwise: byte_valid is 0.
- Extract and accept in the same cycle are combined: acc_next = (acc<<8) | code placed at bit position cnt-8.
- Stuffing: when a byte loaded from acc equals 0xFF, set stuff_pend. EOI bytes never set stuff_pend.
- FSM states:
  - RUN: on flush → PAD. A code accepted in the same cycle as flush is accepted first.
  - PAD (1 cycle): if cnt%8 != 0, fill the bits below the valid data with 1s and round cnt up to the next multiple of 8. Then → DRAIN.
  - DRAIN: wait until cnt==0 and !stuff_pend. Then → EOI1 if EMIT_EOI, else → LAST.
  - EOI1: load 0xFF when the slot is free → EOI2.
  - EOI2: load 0xD9 when the slot is free → LAST.
  - LAST: when the output register is empty, or on the handshake of the held byte: pulse flush_done → RUN.
- In every state other than RUN, in_ready=0, so any jpeg_out_enable there is dropped and sets overflow. flush is ignored outside RUN.
- A flush with no pending data produces only the EOI (or nothing if EMIT_EOI=0), followed by flush_done.

## Timing
- Reset values: byte_out=0, byte_valid=0, in_ready=1 (state RUN, cnt=0), flush_done=0, overflow=0, byte_count=0; acc=0, stuff_pend=0.
- Reset mid-operation discards all pending bits immediately (asynchronous).
- Latency: a code accepted at edge E can appear on byte_out after edge E+1 at the earliest.
- Byte handshake happens on an edge with byte_valid && byte_ready.
- byte_out is held stable while byte_valid && !byte_ready.
- Throughput is 1 byte/cycle; a stuffing byte costs one extra slot.
- byte_count increments on each handshake.
- flush_done is asserted for exactly one cycle, in the cycle after the final handshake edge (or after entering LAST with the register empty).

## Configuration
- BYTE_STUFF_EN defined: 0x00 is inserted after every data 0xFF.
- BYTE_STUFF_EN undefined: stuff_pend is tied to 0 and bytes are emitted raw; the EOI path is unchanged.

## Test plan
- Single code: len=8, code 0xA5 → exactly one byte 0xA5; byte_count=1.
- Stuffing: two len=4 codes 0xF, 0xF → with BYTE_STUFF_EN, bytes 0xFF, 0x00; without it, 0xFF only.
- Flush with padding: len=3 code 0b101, then flush, EMIT_EOI=1 → bytes 0xBF, 0xFF, 0xD9, then a one-cycle flush_done pulse; with EMIT_EOI=0 → 0xBF, then flush_done.
- Backpressure/overflow: byte_ready=0, five back-to-back len=8 codes 0x01..0x05 → in_ready falls after the 4th, 0x05 is dropped, overflow=1. Then byte_ready=1 → 0x01, 0x02, 0x03, 0x04.
- Long code: len=16 code 0x1234 → 0x12, 0x34. Also: len=0 strobe → no byte, overflow stays 0.
- Reset mid-stream: 12 bits pending, held byte stalled, reset_n low → all outputs at reset values. After release, code 0x5A (len 8) → 0x5A only.

Source files
------------

// File: rtl/jpeg_bitstream_packer.sv
// jpeg_bitstream_packer: packs MSB-first Huffman codes into JPEG bytes; define BYTE_STUFF_EN to insert 0x00 after each data 0xFF
module jpeg_bitstream_packer #(
  parameter bit EMIT_EOI = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        jpeg_out_enable,
  input  logic [15:0] jpeg_out,
  input  logic [4:0]  jpeg_code_len,
  input  logic        flush,
  output logic        in_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        flush_done,
  output logic        overflow,
  output logic [15:0] byte_count
);
  typedef enum logic [2:0] {RUN, PAD, DRAIN, EOI1, EOI2, LAST} state_t;
  state_t state, state_next;
  logic [31:0] acc, acc_b, acc_next, pad_mask, code_sh;
  logic [5:0]  cnt, cnt_b, cnt_up, cnt_next, base, sh;
  logic [15:0] code_m;
  logic [7:0]  load_byte;
  logic        accept, drop, slot_free, take_acc, take_eoi, load, stuff_pend;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      RUN:     state_next = flush ? PAD : RUN;
      PAD:     state_next = DRAIN;
      DRAIN:   state_next = (cnt == 6'd0 && !stuff_pend) ? (EMIT_EOI ? EOI1 : LAST) : DRAIN;
      EOI1:    state_next = slot_free ? EOI2 : EOI1;
      EOI2:    state_next = slot_free ? LAST : EOI2;
      LAST:    state_next = slot_free ? RUN : LAST;
      default: state_next = RUN;
    endcase
  end
  // PAD rounds the partial byte up with 1s; extraction in that cycle already sees the padded view
  always_comb begin
    in_ready  = state == RUN && cnt <= 6'd16;
    accept    = jpeg_out_enable && in_ready && jpeg_code_len != 5'd0 && jpeg_code_len <= 5'd16;
    drop      = jpeg_out_enable && jpeg_code_len != 5'd0 && (!in_ready || jpeg_code_len > 5'd16);
    cnt_up    = (cnt + 6'd7) & 6'h38;
    pad_mask  = (32'hFFFF_FFFF >> cnt) & ~(32'hFFFF_FFFF >> cnt_up);
    acc_b     = state == PAD ? acc | pad_mask : acc;
    cnt_b     = state == PAD ? cnt_up : cnt;
    slot_free = !byte_valid || byte_ready;
    take_acc  = slot_free && !stuff_pend && cnt_b >= 6'd8;
    take_eoi  = slot_free && (state == EOI1 || state == EOI2);
    load      = slot_free && (stuff_pend || take_acc || take_eoi);
    load_byte = stuff_pend ? 8'h00 : take_acc ? acc_b[31:24] : state == EOI1 ? 8'hFF : 8'hD9;
    code_m    = jpeg_out & ~(16'hFFFF << jpeg_code_len);
    base      = take_acc ? cnt_b - 6'd8 : cnt_b;
    sh        = 6'd32 - base - {1'b0, jpeg_code_len};
    code_sh   = {16'h0000, code_m} << sh;
    acc_next  = (take_acc ? acc_b << 8 : acc_b) | (accept ? code_sh : 32'h0);
    cnt_next  = base + (accept ? {1'b0, jpeg_code_len} : 6'd0);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      acc        <= '0;
      cnt        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      flush_done <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      acc        <= acc_next;
      cnt        <= cnt_next;
      flush_done <= state == LAST && slot_free;
      overflow   <= overflow | drop;
      if (slot_free) byte_valid <= load;
      if (load) byte_out <= load_byte;
      if (byte_valid && byte_ready) byte_count <= byte_count + 16'd1;
    end
`ifdef BYTE_STUFF_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) stuff_pend <= 1'b0;
    else if (slot_free) stuff_pend <= take_acc && acc_b[31:24] == 8'hFF;
`else
  assign stuff_pend = 1'b0;
`endif
endmodule
